// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse host controller: state codes,
// host commands and the device responses expected during initialisation.
package mouse_pkg;

  typedef enum logic [3:0] {
    ST_INIT_WAIT     = 4'd0,
    ST_SEND_RST      = 4'd1,
    ST_WAIT_RST_SENT = 4'd2,
    ST_WAIT_ACK0     = 4'd3,
    ST_WAIT_SELFTEST = 4'd4,
    ST_WAIT_ID       = 4'd5,
    ST_SEND_EN       = 4'd6,
    ST_WAIT_EN_SENT  = 4'd7,
    ST_WAIT_ACK1     = 4'd8,
    ST_STREAM_B0     = 4'd9,
    ST_STREAM_B1     = 4'd10,
    ST_STREAM_B2     = 4'd11,
    ST_PRESENT       = 4'd12
  } mouse_state_e;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_SELFTEST = 8'hAA;
  localparam logic [7:0] RSP_ID       = 8'h00;

  // Receiver is enabled whenever the state is waiting on a byte from the mouse.
  function automatic logic rx_enabled(input mouse_state_e s);
    case (s)
      ST_WAIT_ACK0, ST_WAIT_SELFTEST, ST_WAIT_ID, ST_WAIT_ACK1,
      ST_STREAM_B0, ST_STREAM_B1, ST_STREAM_B2, ST_PRESENT: rx_enabled = 1'b1;
      default:                                                rx_enabled = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mouse_timeout_counter.sv
// Free-running cycle counter with synchronous clear; done flags the cycle in
// which the count equals the supplied terminal value.
module mouse_timeout_counter #(
  parameter int CTR_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [CTR_W-1:0] terminal_i,
  output logic             done_o
);

  logic [CTR_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign done_o = (count_q == terminal_i);

endmodule

// File: rtl/mouse_master_sm.sv
// PS/2 mouse host controller: power-up handshake (reset, self-test, ID,
// enable streaming) followed by 3-byte packet assembly with a one-cycle interrupt.
module mouse_master_sm
  import mouse_pkg::*;
#(
  parameter int INIT_DELAY   = 5_000_000,
  parameter int RESP_TIMEOUT = 100_000_000,
  parameter int CTR_W        = 27
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_RECEIVED,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic [3:0] MASTER_STATE
);

  mouse_state_e     state_q, state_d;
  logic             send_byte_q;
  logic [7:0]       byte_to_send_q;
  logic             read_enable_q;
  logic [7:0]       status_q, dx_q, dy_q;
  logic [7:0]       status_buf_q, dx_buf_q, dy_buf_q;
  logic             irq_q;
  logic             byte_good;
  logic             timer_done;
  logic [CTR_W-1:0] timer_terminal;
  logic [7:0]       rsp_expected;
  mouse_state_e     rsp_next;

  assign byte_good = BYTE_RECEIVED && (BYTE_ERROR_CODE == 2'b00);

  // One counter serves both the power-up delay and the response timeout.
  assign timer_terminal = (state_q == ST_INIT_WAIT) ? CTR_W'(INIT_DELAY - 1)
                                                    : CTR_W'(RESP_TIMEOUT - 1);

  mouse_timeout_counter #(
    .CTR_W(CTR_W)
  ) u_timer (
    .clk       (CLK),
    .rst       (RESET),
    .clear_i   (state_d != state_q),
    .terminal_i(timer_terminal),
    .done_o    (timer_done)
  );

  always_comb begin
    rsp_expected = RSP_ACK;
    rsp_next     = ST_WAIT_SELFTEST;
    case (state_q)
      ST_WAIT_SELFTEST: begin rsp_expected = RSP_SELFTEST; rsp_next = ST_WAIT_ID;   end
      ST_WAIT_ID:       begin rsp_expected = RSP_ID;       rsp_next = ST_SEND_EN;   end
      ST_WAIT_ACK1:     begin rsp_expected = RSP_ACK;      rsp_next = ST_STREAM_B0; end
      default:          ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT_WAIT: if (timer_done) state_d = ST_SEND_RST;
      ST_SEND_RST:  state_d = ST_WAIT_RST_SENT;
      ST_SEND_EN:   state_d = ST_WAIT_EN_SENT;
      ST_WAIT_RST_SENT, ST_WAIT_EN_SENT: begin
        if (BYTE_SENT)       state_d = (state_q == ST_WAIT_RST_SENT) ? ST_WAIT_ACK0 : ST_WAIT_ACK1;
        else if (timer_done) state_d = ST_INIT_WAIT;
      end
      ST_WAIT_ACK0, ST_WAIT_SELFTEST, ST_WAIT_ID, ST_WAIT_ACK1: begin
        if (BYTE_RECEIVED)   state_d = (byte_good && BYTE_READ == rsp_expected) ? rsp_next : ST_INIT_WAIT;
        else if (timer_done) state_d = ST_INIT_WAIT;
      end
      // Byte 0 must carry the always-one bit 3; anything else is a resync.
      ST_STREAM_B0: if (byte_good && BYTE_READ[3]) state_d = ST_STREAM_B1;
      ST_STREAM_B1: begin
        if (byte_good)          state_d = ST_STREAM_B2;
        else if (BYTE_RECEIVED) state_d = ST_STREAM_B0;
      end
      ST_STREAM_B2: begin
        if (byte_good)          state_d = ST_PRESENT;
        else if (BYTE_RECEIVED) state_d = ST_STREAM_B0;
      end
      ST_PRESENT:   state_d = ST_STREAM_B0;
      default:      state_d = ST_INIT_WAIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= ST_INIT_WAIT;
      send_byte_q    <= 1'b0;
      byte_to_send_q <= 8'h00;
      read_enable_q  <= 1'b0;
      status_q       <= 8'h00;
      dx_q           <= 8'h00;
      dy_q           <= 8'h00;
      status_buf_q   <= 8'h00;
      dx_buf_q       <= 8'h00;
      dy_buf_q       <= 8'h00;
      irq_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      send_byte_q   <= 1'b0;
      irq_q         <= 1'b0;
      read_enable_q <= rx_enabled(state_d);
      case (state_q)
        ST_SEND_RST: begin
          send_byte_q    <= 1'b1;
          byte_to_send_q <= CMD_RESET;
        end
        ST_SEND_EN: begin
          send_byte_q    <= 1'b1;
          byte_to_send_q <= CMD_ENABLE;
        end
        ST_STREAM_B0: if (byte_good && BYTE_READ[3]) status_buf_q <= BYTE_READ;
        ST_STREAM_B1: if (byte_good) dx_buf_q <= BYTE_READ;
        ST_STREAM_B2: if (byte_good) dy_buf_q <= BYTE_READ;
        // Only a complete packet reaches the outputs, all three bytes at once.
        ST_PRESENT: begin
          status_q <= status_buf_q;
          dx_q     <= dx_buf_q;
          dy_q     <= dy_buf_q;
          irq_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign SEND_BYTE      = send_byte_q;
  assign BYTE_TO_SEND   = byte_to_send_q;
  assign READ_ENABLE    = read_enable_q;
  assign MOUSE_STATUS   = status_q;
  assign MOUSE_DX       = dx_q;
  assign MOUSE_DY       = dy_q;
  assign SEND_INTERRUPT = irq_q;
  assign MASTER_STATE   = state_q;

endmodule

// File: tb/tb_mouse_master_sm.sv
// Scoreboard bench for mouse_master_sm: stimulus pushes expected commands and
// packets, a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_mouse_master_sm;
  import mouse_pkg::*;

  localparam int INIT_DELAY   = 10;
  localparam int RESP_TIMEOUT = 50;
  localparam int CTR_W        = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic       BYTE_RECEIVED = 1'b0;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic [3:0] MASTER_STATE;

  mouse_master_sm #(
    .INIT_DELAY  (INIT_DELAY),
    .RESP_TIMEOUT(RESP_TIMEOUT),
    .CTR_W       (CTR_W)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .SEND_BYTE      (SEND_BYTE),
    .BYTE_TO_SEND   (BYTE_TO_SEND),
    .BYTE_SENT      (BYTE_SENT),
    .READ_ENABLE    (READ_ENABLE),
    .BYTE_READ      (BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE_RECEIVED  (BYTE_RECEIVED),
    .MOUSE_STATUS   (MOUSE_STATUS),
    .MOUSE_DX       (MOUSE_DX),
    .MOUSE_DY       (MOUSE_DY),
    .SEND_INTERRUPT (SEND_INTERRUPT),
    .MASTER_STATE   (MASTER_STATE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;
  logic [7:0]  exp_cmd_q[$];
  logic [23:0] exp_pkt_q[$];
  logic [7:0]  partial_q[$];
  logic [23:0] shown = 24'h0;
  logic        irq_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_evt(input string name);
    checks++;
    $display("FAIL %s: got an output event, expected none", name);
  endtask

  // Packet model: errors drop the partial packet; a first byte without bit 3 is discarded.
  task automatic model_byte(input logic [7:0] b, input logic [1:0] e, output bit done);
    done = 1'b0;
    if (e != 2'b00) begin
      partial_q.delete();
    end else if (partial_q.size() != 0 || b[3]) begin
      partial_q.push_back(b);
      if (partial_q.size() == 3) begin
        exp_pkt_q.push_back({partial_q[0], partial_q[1], partial_q[2]});
        partial_q.delete();
        done = 1'b1;
      end
    end
  endtask

  // All stimulus tasks start and end 1 ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic rx(input logic [7:0] b, input logic [1:0] e);
    BYTE_READ = b; BYTE_ERROR_CODE = e; BYTE_RECEIVED = 1'b1;
    @(posedge CLK); #1;
    BYTE_RECEIVED = 1'b0; BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic stream(input logic [7:0] b, input logic [1:0] e, output bit done);
    model_byte(b, e, done);
    rx(b, e);
  endtask

  task automatic sent();
    BYTE_SENT = 1'b1;
    @(posedge CLK); #1;
    BYTE_SENT = 1'b0;
  endtask

  task automatic wait_send(input int exp_lat, input string name);
    int n = 0;
    while (SEND_BYTE !== 1'b1 && n < 1000) begin @(posedge CLK); #1; n++; end
    chk(name, 32'(n), 32'(exp_lat));
  endtask

  task automatic wait_state(input mouse_state_e s, input int exp_lat, input string name);
    int n = 0;
    while (MASTER_STATE !== 4'(s) && n < 1000) begin @(posedge CLK); #1; n++; end
    chk(name, 32'(n), 32'(exp_lat));
  endtask

  task automatic do_init(input int lat);
    exp_cmd_q.push_back(CMD_RESET);
    wait_send(lat, "rst_cmd_latency");
    chk("re_off_while_sending", 32'(READ_ENABLE), 32'd0);
    rx(RSP_ACK, 2'b00);
    chk("rx_ignored_in_rst_sent", 32'(MASTER_STATE), 32'(ST_WAIT_RST_SENT));
    sent();
    chk("state_ack0", 32'(MASTER_STATE), 32'(ST_WAIT_ACK0));
    chk("re_on_ack0", 32'(READ_ENABLE), 32'd1);
    rx(RSP_ACK, 2'b00);
    rx(RSP_SELFTEST, 2'b00);
    rx(RSP_ID, 2'b00);
    exp_cmd_q.push_back(CMD_ENABLE);
    wait_send(1, "en_cmd_latency");
    sent();
    rx(RSP_ACK, 2'b00);
    chk("state_stream_b0", 32'(MASTER_STATE), 32'(ST_STREAM_B0));
    chk("re_on_stream", 32'(READ_ENABLE), 32'd1);
  endtask

  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (RESET) begin
        shown    = 24'h0;
        irq_prev = 1'b0;
      end else begin
        if (SEND_BYTE) begin
          if (exp_cmd_q.size() == 0) fail_evt("unexpected_send_byte");
          else chk("cmd_byte", 32'(BYTE_TO_SEND), 32'(exp_cmd_q.pop_front()));
        end
        if (SEND_INTERRUPT) begin
          chk("irq_one_cycle", 32'(irq_prev), 32'd0);
          if (exp_pkt_q.size() == 0) fail_evt("unexpected_interrupt");
          else shown = exp_pkt_q.pop_front();
        end
        chk("packet_outputs", {8'h0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, {8'h0, shown});
        irq_prev = SEND_INTERRUPT;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no completion, expected $finish before 300 us");
    $fatal(1);
  end

  initial begin : stimulus
    bit         done;
    logic [7:0] b;
    logic [1:0] e;

    tick(3);
    chk("reset_outputs", {15'h0, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, SEND_INTERRUPT, MASTER_STATE, 2'b0},
        32'h0);
    chk("reset_packet", {8'h0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 32'h0);
    RESET = 1'b0;
    do_init(INIT_DELAY + 1);

    // Directed packet
    stream(8'h09, 2'b00, done);
    stream(8'h05, 2'b00, done);
    stream(8'hFB, 2'b00, done);
    chk("irq_not_yet", 32'(SEND_INTERRUPT), 32'd0);
    tick(1);
    chk("pkt_directed", {8'h0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 32'h0009_05FB);
    chk("irq_high", 32'(SEND_INTERRUPT), 32'd1);
    tick(1);
    chk("irq_low", 32'(SEND_INTERRUPT), 32'd0);

    // Resync and stream error
    stream(8'h00, 2'b00, done);
    chk("resync_stay_b0", 32'(MASTER_STATE), 32'(ST_STREAM_B0));
    stream(8'h08, 2'b00, done);
    chk("b0_accepted", 32'(MASTER_STATE), 32'(ST_STREAM_B1));
    stream(8'h11, 2'b01, done);
    chk("err_back_to_b0", 32'(MASTER_STATE), 32'(ST_STREAM_B0));
    chk("err_outputs_held", {8'h0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 32'h0009_05FB);

    // Randomised stream, including errors and misaligned first bytes
    for (int i = 0; i < 80; i++) begin
      b = 8'($urandom);
      if (partial_q.size() == 0 && $urandom_range(0, 3) != 0) b[3] = 1'b1;
      e = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      stream(b, e, done);
      if (done) tick(1);
      else tick($urandom_range(0, 2));
    end
    stream(8'h00, 2'b10, done);
    tick(2);

    // Reset in the middle of a packet
    stream(8'h0C, 2'b00, done);
    stream(8'h33, 2'b00, done);
    #2 RESET = 1'b1;
    #1;
    chk("async_reset_outputs", {15'h0, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, SEND_INTERRUPT, MASTER_STATE, 2'b0},
        32'h0);
    chk("async_reset_packet", {8'h0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 32'h0);
    partial_q.delete();
    tick(3);
    RESET = 1'b0;

    // Wrong response to the reset command restarts the init sequence
    exp_cmd_q.push_back(CMD_RESET);
    wait_send(INIT_DELAY + 1, "post_reset_cmd_latency");
    sent();
    rx(8'hFE, 2'b00);
    chk("bad_rsp_init_wait", 32'(MASTER_STATE), 32'(ST_INIT_WAIT));
    chk("re_off_init_wait", 32'(READ_ENABLE), 32'd0);
    exp_cmd_q.push_back(CMD_RESET);
    wait_send(INIT_DELAY + 1, "retry_cmd_latency");

    // No BYTE_SENT: response timeout
    wait_state(ST_INIT_WAIT, RESP_TIMEOUT, "timeout_latency");
    do_init(INIT_DELAY + 1);

    stream(8'h2A, 2'b00, done);
    stream(8'h80, 2'b00, done);
    stream(8'h7F, 2'b00, done);
    tick(2);
    chk("pkt_after_recovery", {8'h0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 32'h002A_807F);
    tick(5);
    chk("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
    chk("pkt_queue_drained", 32'(exp_pkt_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
